// File: rtl/fir_coef_pkg.sv
// rtl/fir_coef_pkg.sv - shared FSM state, register offsets and bit positions for fir_coef_loader
package fir_coef_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_SAMPLE,
      ST_LOAD,
      ST_SWAP
   } state_t;

   localparam int REG_CTRL   = 0;
   localparam int REG_STATUS = 1;

   localparam int CTRL_COMMIT_BIT = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;

   localparam int STAT_BUSY_BIT    = 0;
   localparam int STAT_DONE_BIT    = 1;
   localparam int STAT_OVERRUN_BIT = 2;

endpackage

// File: rtl/fir_coef_ram.sv
// rtl/fir_coef_ram.sv - simple dual-port shadow coefficient RAM, synchronous read, no reset
module fir_coef_ram #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Kept free of reset so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - shadow-RAM coefficient reload sequencer for the FIR
// Optional FIR_COEF_SAMPLE_ALIGN_EN: wait for a sample_ready rising edge before streaming.
module fir_coef_loader
   import fir_coef_pkg::*;
#(
   parameter int NUM_TAPS = 64,
   parameter int COEF_W   = 16,
   parameter int ADDR_W   = $clog2(NUM_TAPS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W:0]   avs_address,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic              avs_read,
   output logic [31:0]       avs_readdata,
   output logic              avs_waitrequest,
   input  logic              sample_ready,
   output logic [COEF_W-1:0] coef_data,
   output logic              load_coef,
   output logic              change_filter,
   output logic              irq
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAPS - 1);

   state_t              state;
   logic [ADDR_W-1:0]   idx;
   logic                busy;
   logic                done;
   logic                overrun;
   logic                irq_en;
   logic [COEF_W-1:0]   ram_q;
   logic [ADDR_W-1:0]   rd_addr;
   logic                issue;
   logic                is_reg;
   logic [ADDR_W-1:0]   offset;
   logic                ctrl_wr;
   logic                status_wr;
   logic                commit;
   logic                coef_wr;
   logic                unused_wdata;

   assign is_reg    = avs_address[ADDR_W];
   assign offset    = avs_address[ADDR_W-1:0];
   assign ctrl_wr   = avs_write & is_reg & (offset == ADDR_W'(REG_CTRL));
   assign status_wr = avs_write & is_reg & (offset == ADDR_W'(REG_STATUS));
   assign commit    = ctrl_wr & avs_writedata[CTRL_COMMIT_BIT];

   // Only coefficient writes stall, and only while the RAM is being streamed out.
   assign avs_waitrequest = avs_write & ~is_reg & (state == ST_LOAD);
   assign coef_wr         = avs_write & ~is_reg & ~avs_waitrequest;

`ifdef FIR_COEF_SAMPLE_ALIGN_EN
   logic sample_q;
   logic sample_rise;
   assign sample_rise = sample_ready & ~sample_q;
   // The exit cycle of WAIT_SAMPLE issues the first read so data meets load_coef.
   assign issue = (state == ST_LOAD) | ((state == ST_WAIT_SAMPLE) & sample_rise);
`else
   logic unused_sample;
   assign unused_sample = sample_ready;
   assign issue         = (state == ST_LOAD);
`endif

   assign unused_wdata = &avs_writedata;
   assign rd_addr      = LAST_IDX - idx;
   assign coef_data    = ram_q & {COEF_W{load_coef}};
   assign irq          = done & irq_en;

   fir_coef_ram #(
      .DEPTH (NUM_TAPS),
      .WIDTH (COEF_W),
      .AW    (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (coef_wr),
      .waddr (offset),
      .wdata (avs_writedata[COEF_W-1:0]),
      .re    (issue),
      .raddr (rd_addr),
      .rdata (ram_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         idx           <= '0;
         load_coef     <= 1'b0;
         change_filter <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         overrun       <= 1'b0;
         irq_en        <= 1'b0;
         avs_readdata  <= '0;
`ifdef FIR_COEF_SAMPLE_ALIGN_EN
         sample_q      <= 1'b0;
`endif
      end else begin
`ifdef FIR_COEF_SAMPLE_ALIGN_EN
         sample_q <= sample_ready;
`endif
         load_coef     <= issue;
         change_filter <= (state == ST_SWAP);

         if (issue) begin
            idx <= idx + ADDR_W'(1);
         end

         // busy spans from the cycle after commit through the change_filter cycle.
         if (change_filter) begin
            busy <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (commit && !busy) begin
                  busy <= 1'b1;
`ifdef FIR_COEF_SAMPLE_ALIGN_EN
                  state <= ST_WAIT_SAMPLE;
`else
                  state <= ST_LOAD;
`endif
               end
            end
            ST_WAIT_SAMPLE: begin
`ifdef FIR_COEF_SAMPLE_ALIGN_EN
               if (sample_rise) begin
                  state <= ST_LOAD;
               end
`else
               state <= ST_IDLE;
`endif
            end
            ST_LOAD: begin
               if (idx == LAST_IDX) begin
                  state <= ST_SWAP;
               end
            end
            ST_SWAP: begin
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         if (ctrl_wr) begin
            irq_en <= avs_writedata[CTRL_IRQ_EN_BIT];
         end

         // Clear first so a same-cycle hardware set takes precedence.
         if (status_wr && avs_writedata[STAT_DONE_BIT]) begin
            done <= 1'b0;
         end
         if (state == ST_SWAP) begin
            done <= 1'b1;
         end
         if (status_wr && avs_writedata[STAT_OVERRUN_BIT]) begin
            overrun <= 1'b0;
         end
         if (commit && busy) begin
            overrun <= 1'b1;
         end

         if (avs_read) begin
            avs_readdata <= '0;
            if (is_reg && offset == ADDR_W'(REG_CTRL)) begin
               avs_readdata[CTRL_IRQ_EN_BIT] <= irq_en;
            end else if (is_reg && offset == ADDR_W'(REG_STATUS)) begin
               avs_readdata[STAT_BUSY_BIT]    <= busy;
               avs_readdata[STAT_DONE_BIT]    <= done;
               avs_readdata[STAT_OVERRUN_BIT] <= overrun;
            end
         end
      end
   end

endmodule
